bit_deserializer: RTL

Serial-to-parallel assembler: accepts one bit per handshake on a valid/ready input and writes it into a WIDTH-bit word at a tracked bit index, MSB-first or LSB-first. It presents the completed word on a valid/ready output. It is the write-side counterpart of the indexed bit-select exercises, taking a word such as 8'hF2 apart bit by bit and rebuilding it on the far end. It sits between a bit-serial source (bench driver, future UART-style receiver) and any byte-wide consumer.

---
 rtl/bit_deserializer_pkg.sv | 18 +
 rtl/bit_index_counter.sv | 41 ++++
 rtl/bit_deserializer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bit_deserializer_pkg.sv
// Shared types and constants for the bit deserializer.
package bit_deser_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Index counter width; never below 1 bit.
  function automatic int unsigned idx_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/bit_index_counter.sv
// Loadable up/down bit-index counter with a flag marking the final position.
module bit_index_counter
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned IDX_W    = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic             last_c
);

  localparam logic [IDX_W-1:0] START_IDX = MSB_FIRST ? IDX_W'(WIDTH - 1) : '0;
  localparam logic [IDX_W-1:0] FINAL_IDX = MSB_FIRST ? '0 : IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx_q, idx_d;

  assign last_c = (idx_q == FINAL_IDX);
  assign idx    = idx_q;

  // Reload on word release; otherwise step toward the final position and park there.
  always_comb begin
    idx_d = idx_q;
    if (load) begin
      idx_d = START_IDX;
    end else if (step && !last_c) begin
      idx_d = MSB_FIRST ? (idx_q - IDX_W'(1)) : (idx_q + IDX_W'(1));
    end
  end

  // Index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) idx_q <= START_IDX;
    else        idx_q <= idx_d;
  end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel word assembler with valid/ready on both sides.
// Optional trailing even-parity bit: define BIT_DESER_PARITY_EN.
module bit_deserializer
  import bit_deser_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             parity_err
);

  localparam int unsigned IDX_W = idx_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] idx;
  logic             last_c;
  logic             accept_c;
  logic             data_acc_c;
  logic             release_c;

  // in_ready depends only on state and enable; held low during reset.
  assign in_ready   = rst_n & enable & (state_q != HOLD);
  assign accept_c   = in_valid & in_ready;
  assign data_acc_c = accept_c & ((state_q == IDLE) || (state_q == SHIFT));
  assign release_c  = (state_q == HOLD) & out_ready;

  // Bit position for the next data bit.
  bit_index_counter #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (release_c),
    .step   (data_acc_c),
    .idx    (idx),
    .last_c (last_c)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (data_acc_c) state_d = SHIFT;
      end
      SHIFT: begin
        if (data_acc_c && last_c) begin
`ifdef BIT_DESER_PARITY_EN
          state_d = PARITY;
`else
          state_d = HOLD;
`endif
        end
      end
`ifdef BIT_DESER_PARITY_EN
      PARITY: begin
        if (accept_c) state_d = HOLD;
      end
`endif
      HOLD: begin
        if (release_c) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: bit insertion, word capture, output valid.
  always_comb begin
    word_d      = word_q;
    out_data_d  = out_data_q;
    out_valid_d = (state_d == HOLD);
    if (release_c) begin
      word_d = '0;
    end else if (data_acc_c) begin
      word_d[idx] = in_bit;
    end
    if (data_acc_c && (state_q == SHIFT) && last_c) begin
      out_data_d = word_d;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q      <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;

`ifdef BIT_DESER_PARITY_EN
  logic parity_err_q, parity_err_d;

  // Even-parity check over the completed word plus the received parity bit.
  always_comb begin
    parity_err_d = parity_err_q;
    if (release_c) begin
      parity_err_d = 1'b0;
    end else if (accept_c && (state_q == PARITY)) begin
      parity_err_d = ^{word_q, in_bit};
    end
  end

  // Parity flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err_q <= 1'b0;
    else        parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule
